// File: rtl/branch_pc_unit.sv
// Fetch-stage PC register with MIPS branch/jump resolution (delay-slot semantics),
// stall hold, sticky misaligned-jr flag and branch performance counters.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  br_type,
  input  logic        eq,
  input  logic        neq,
  input  logic        lez,
  input  logic        ltz,
  input  logic        gez,
  input  logic        gtz,
  input  logic [1:0]  j_type,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] jr_target,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_f,
  output logic        taken,
  output logic [31:0] link_addr,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count,
  output logic        misalign
);

  logic        cond_s;
  logic        br_valid_s;
  logic        jump_s;
  logic [31:0] br_target_s;
  logic [31:0] next_pc_s;
  logic [31:0] pc_r;
  logic [31:0] br_count_r;
  logic [31:0] br_taken_count_r;
  logic        misalign_r;

  // Branch condition select from comparator flags; reserved kinds never fire
  always_comb begin
    cond_s     = 1'b0;
    br_valid_s = 1'b0;
    case (br_type)
      3'd1:    begin cond_s = eq;  br_valid_s = 1'b1; end
      3'd2:    begin cond_s = neq; br_valid_s = 1'b1; end
      3'd3:    begin cond_s = lez; br_valid_s = 1'b1; end
      3'd4:    begin cond_s = gtz; br_valid_s = 1'b1; end
      3'd5:    begin cond_s = ltz; br_valid_s = 1'b1; end
      3'd6:    begin cond_s = gez; br_valid_s = 1'b1; end
      default: begin cond_s = 1'b0; br_valid_s = 1'b0; end
    endcase
  end

  assign jump_s      = (j_type == 2'd1) || (j_type == 2'd2);
  assign br_target_s = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

  // Next-PC priority: j/jal, jr/jalr, taken branch, sequential
  always_comb begin
    next_pc_s = pc_r + 32'd4;
    if (j_type == 2'd1) begin
      next_pc_s = {pc_d[31:28], imm26, 2'b00};
    end else if (j_type == 2'd2) begin
      next_pc_s = {jr_target[31:2], 2'b00};
    end else if (cond_s) begin
      next_pc_s = br_target_s;
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  // PC, counters and sticky misalign flag; everything holds while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r             <= RESET_PC;
      br_count_r       <= 32'd0;
      br_taken_count_r <= 32'd0;
      misalign_r       <= 1'b0;
    end else if (!stall) begin
      pc_r <= next_pc_s;
      // An illegal jump+branch decode resolves as the jump and is not counted
      if (br_valid_s && !jump_s) begin
        br_count_r <= br_count_r + 32'd1;
        if (cond_s) begin
          br_taken_count_r <= br_taken_count_r + 32'd1;
        end
      end
      if ((j_type == 2'd2) && (jr_target[1:0] != 2'b00)) begin
        misalign_r <= 1'b1;
      end
    end
  end

  assign pc_f           = pc_r;
  assign br_count       = br_count_r;
  assign br_taken_count = br_taken_count_r;
  assign misalign       = misalign_r;
  assign taken          = jump_s | cond_s;
  assign link_addr      = pc_d + 32'd8;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit: reset, branches, stall,
// jumps, misalign, jump/branch conflict and PC wrap.
module tb_branch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  br_type;
  logic        eq, neq, lez, ltz, gez, gtz;
  logic [1:0]  j_type;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] jr_target;
  logic [31:0] pc_d;
  logic [31:0] pc_f;
  logic        taken;
  logic [31:0] link_addr;
  logic [31:0] br_count;
  logic [31:0] br_taken_count;
  logic        misalign;

  int passed;
  int total;

  branch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_type(br_type),
    .eq(eq), .neq(neq), .lez(lez), .ltz(ltz), .gez(gez), .gtz(gtz),
    .j_type(j_type), .imm16(imm16), .imm26(imm26), .jr_target(jr_target),
    .pc_d(pc_d), .pc_f(pc_f), .taken(taken), .link_addr(link_addr),
    .br_count(br_count), .br_taken_count(br_taken_count), .misalign(misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall = 1'b0; br_type = 3'd0; j_type = 2'd0;
    eq = 1'b0; neq = 1'b0; lez = 1'b0; ltz = 1'b0; gez = 1'b0; gtz = 1'b0;
    imm16 = 16'h0000; imm26 = 26'h0; jr_target = 32'h0; pc_d = 32'h0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    check("reset_pc", pc_f, 32'h0000_3000);
    check("reset_brc", br_count, 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    check("seq_pc", pc_f, 32'h0000_3010);

    // Mid-cycle async reset
    #1 reset = 1'b1;
    #1;
    check("async_reset_pc", pc_f, 32'h0000_3000);
    check("async_reset_brc", br_count, 32'd0);
    check("async_reset_btc", br_taken_count, 32'd0);
    check("async_reset_mis", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_reset_pc", pc_f, 32'h0000_3004);

    // beq taken backwards to itself
    pc_d = 32'h0000_3000; br_type = 3'd1; eq = 1'b1; imm16 = 16'hFFFF;
    #1 check("beq_taken_flag", {31'd0, taken}, 32'd1);
    tick();
    check("beq_pc", pc_f, 32'h0000_3000);
    check("beq_brc", br_count, 32'd1);
    check("beq_btc", br_taken_count, 32'd1);

    // bne not taken
    clear_inputs();
    repeat (2) tick();
    check("pre_bne_pc", pc_f, 32'h0000_3008);
    pc_d = 32'h0000_3004; br_type = 3'd2; neq = 1'b0; eq = 1'b1; imm16 = 16'h0010;
    #1 check("bne_taken_flag", {31'd0, taken}, 32'd0);
    tick();
    check("bne_pc", pc_f, 32'h0000_300C);
    check("bne_brc", br_count, 32'd2);
    check("bne_btc", br_taken_count, 32'd1);

    // bgez held under a 3-cycle stall
    clear_inputs();
    pc_d = 32'h0000_3008; br_type = 3'd6; gez = 1'b1; imm16 = 16'h0004; stall = 1'b1;
    repeat (3) tick();
    check("stall_pc", pc_f, 32'h0000_300C);
    check("stall_brc", br_count, 32'd2);
    check("stall_btc", br_taken_count, 32'd1);
    stall = 1'b0;
    tick();
    check("unstall_pc", pc_f, 32'h0000_301C);
    check("unstall_brc", br_count, 32'd3);
    check("unstall_btc", br_taken_count, 32'd2);
    clear_inputs();
    tick();
    check("after_stall_pc", pc_f, 32'h0000_3020);
    check("after_stall_brc", br_count, 32'd3);

    // Condition select: blez must use lez only; reserved br_type never taken
    br_type = 3'd3; eq = 1'b1; neq = 1'b1; ltz = 1'b1; gez = 1'b1; gtz = 1'b1; lez = 1'b0;
    #1 check("blez_sel_flag", {31'd0, taken}, 32'd0);
    br_type = 3'd4; gtz = 1'b0; lez = 1'b1;
    #1 check("bgtz_sel_flag", {31'd0, taken}, 32'd0);
    br_type = 3'd5; gtz = 1'b1; ltz = 1'b1;
    #1 check("bltz_sel_flag", {31'd0, taken}, 32'd1);
    clear_inputs();
    @(negedge clk);

    // jal
    pc_d = 32'h3000_0010; j_type = 2'd1; imm26 = 26'h0000100;
    #1 check("jal_link", link_addr, 32'h3000_0018);
    check("jal_taken_flag", {31'd0, taken}, 32'd1);
    tick();
    check("jal_pc", pc_f, 32'h3000_0400);
    check("jal_brc", br_count, 32'd3);

    // misaligned jr
    clear_inputs();
    j_type = 2'd2; jr_target = 32'h0000_3002;
    #1 check("jr_mis_before", {31'd0, misalign}, 32'd0);
    tick();
    check("jr_pc", pc_f, 32'h0000_3000);
    check("jr_mis", {31'd0, misalign}, 32'd1);
    clear_inputs();
    tick();
    check("jr_mis_sticky", {31'd0, misalign}, 32'd1);
    check("jr_next_pc", pc_f, 32'h0000_3004);

    // jump/branch conflict: jump wins, no counting
    j_type = 2'd1; br_type = 3'd1; eq = 1'b1; pc_d = 32'h0000_2000;
    imm26 = 26'h0000C00; imm16 = 16'h0100;
    tick();
    check("conflict_pc", pc_f, 32'h0000_3000);
    check("conflict_brc", br_count, 32'd3);
    check("conflict_btc", br_taken_count, 32'd2);

    // PC wrap
    clear_inputs();
    j_type = 2'd2; jr_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_pre_pc", pc_f, 32'hFFFF_FFFC);
    clear_inputs();
    tick();
    check("wrap_pc", pc_f, 32'h0000_0000);

    // reserved br_type 7 with all flags set
    br_type = 3'd7; eq = 1'b1; neq = 1'b1; lez = 1'b1; ltz = 1'b1; gez = 1'b1; gtz = 1'b1;
    imm16 = 16'h0040; pc_d = 32'h0000_1000;
    #1 check("rsv_taken_flag", {31'd0, taken}, 32'd0);
    tick();
    check("rsv_pc", pc_f, 32'h0000_0004);
    check("rsv_brc", br_count, 32'd3);

    // reset during stall
    clear_inputs();
    stall = 1'b1;
    tick();
    #1 reset = 1'b1;
    #1;
    check("stall_reset_pc", pc_f, 32'h0000_3000);
    check("stall_reset_mis", {31'd0, misalign}, 32'd0);
    check("stall_reset_brc", br_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    tick();
    check("final_pc", pc_f, 32'h0000_3004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Fetch-stage program counter and branch/jump resolution unit for the five-stage MIPS pipeline. It consumes the six condition flags produced by the D-stage register comparator, the D-stage branch/jump decode and immediates, and owns the PC register. It redirects fetch with MIPS delay-slot semantics, honours the hazard stall, flags misaligned register jumps, and keeps branch performance counters.

## Interface

- RESET_PC, 32'h0000_3000, PC value loaded on reset
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard stall; PC and all state hold
- br_type  in  3  D-stage branch kind: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none)
- eq, neq, lez, ltz, gez, gtz  in  1 each  comparator flags for the D-stage operands
- j_type  in  2  0 none, 1 j/jal (imm26), 2 jr/jalr (register), 3 reserved (treated as none)
- imm16  in  16  D-stage branch offset
- imm26  in  26  D-stage jump index
- jr_target  in  32  forwarded rs value for jr/jalr
- pc_d  in  32  PC of the D-stage instruction
- pc_f  out  32  current fetch PC (registered)
- taken  out  1  combinational: D-stage branch condition true or jump present
- link_addr  out  32  combinational, pc_d + 8
- br_count  out  32  branches resolved (registered)
- br_taken_count  out  32  branches resolved taken (registered)
- misalign  out  1  sticky: a jr/jalr target with nonzero bits [1:0] was accepted

## Operation

- Condition select: beq→eq, bne→neq, blez→lez, bgtz→gtz, bltz→ltz, bgez→gez; br_type 0/7 → cond = 0.
- Next PC, priority order:
  - j_type 1: {pc_d[31:28], imm26, 2'b00}
  - j_type 2: {jr_target[31:2], 2'b00}
  - br_type valid and cond: pc_d + 4 + (sign-extended imm16 << 2), mod 2^32
  - otherwise: pc_f + 4, mod 2^32
- Jump and branch both active (illegal decode): jump wins; branch counters do not increment.
- taken = (j_type ∈ {1,2}) | cond.
- Counters: on an accepted edge (stall = 0) with a valid br_type and no jump, br_count += 1; additionally br_taken_count += 1 if cond. Both wrap 2^32−1 → 0.
- misalign: set on an accepted edge with j_type = 2 and jr_target[1:0] ≠ 0; cleared only by reset.
- Stall: pc_f, counters and misalign hold. The D-stage instruction is re-presented next cycle and is counted exactly once, when stall drops.

## Timing

- Reset (async, any time, including mid-stall): pc_f = RESET_PC, br_count = 0, br_taken_count = 0, misalign = 0 immediately; first update on the first rising edge with reset low.
- pc_f updates on the rising clk edge; redirect latency is 1 cycle: a branch resolved in D during cycle n gives pc_f = target in cycle n+1. The instruction fetched in cycle n (delay slot) is always executed; no flush output.
- taken and link_addr are combinational from current inputs, with no registered delay.
- Back-to-back branches on consecutive accepted cycles are each counted and each redirect.

## Test plan

- Reset: assert reset mid-cycle with pc_f = 0x3010 → pc_f = 0x3000 before next edge; counters 0, misalign 0.
- beq taken: pc_d = 0x3000, pc_f = 0x3004, br_type 1, eq 1, imm16 0xFFFF → next pc_f = 0x3000, taken 1, br_count 1, br_taken_count 1.
- bne not taken: br_type 2, neq 0, pc_f = 0x3008 → next pc_f = 0x300C, taken 0, br_count +1, br_taken_count unchanged.
- Stall: bgez with gez 1 held 3 cycles with stall 1, then stall 0 → pc_f frozen for 3 cycles, redirects once; br_count +1 only.
- jal then misaligned jr: pc_d = 0x3000_0010, imm26 0x0000100 → pc_f = 0x3000_0400, link_addr 0x3000_0018; next jr_target 0x3002 → pc_f = 0x3000, misalign 1 and stays 1.
- Conflict and wrap: j_type 1 with br_type 1, eq 1 → jump target, counters unchanged; pc_f = 0xFFFF_FFFC with no branch → pc_f = 0x0000_0000.
